// File: rtl/uart_rx_seq.sv
// uart_rx_seq: UART receive sequencer. It detects the start bit, samples each bit at its
// centre from the oversampling tick, checks parity and framing, and writes good characters
// to the RX FIFO.
// Optional build macro UART_RX_MAJORITY_EN selects a 2-of-3 vote around each sample point.
// When it is enabled, every decision happens one tick later.
module uart_rx_seq #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ON  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic                 fifo_full,
    input  logic                 err_clr,
    output logic                 fifo_we,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int MID = OVERSAMPLE / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   xor_q, xor_d;
    logic                   ppend_q, ppend_d;   // parity mismatch seen in this frame
    logic                   fin_q, fin_d;       // stop bit decided on the previous edge
    logic                   stop_q, stop_d;     // decided stop-bit value
    logic                   we_q, we_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
    logic                   samp;               // this tick is the decision point of a bit
    logic                   bit_val;            // decided line value at that point

`ifdef UART_RX_MAJORITY_EN
    // The counter starts one tick into the period so that bit periods stay aligned after
    // the one-tick-late start decision.
    localparam logic [TW-1:0] TRELOAD = TW'(1);
    logic [1:0] hist_q;
    logic       arm_q, arm_d;

    // Keep the last two tick samples of the line; arm the vote on the tick before the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            arm_q  <= 1'b0;
        end else begin
            arm_q <= arm_d;
            if (baud_tick) hist_q <= {hist_q[0], rx_in};
        end
    end

    // The vote window is the two stored samples plus the current tick.
    always_comb begin
        arm_d = arm_q;
        if (baud_tick)
            arm_d = (state_q == START && tick_q == TW'(MID - 1)) ||
                    ((state_q == DATA || state_q == PARITY || state_q == STOP) &&
                     tick_q == TW'(OVERSAMPLE - 1));
        samp    = arm_q;
        bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_in) | (hist_q[0] & rx_in);
    end
`else
    localparam logic [TW-1:0] TRELOAD = '0;

    // Single sample taken at the bit centre.
    always_comb begin
        samp    = (state_q == START) ? (tick_q == TW'(MID - 1)) : (tick_q == TW'(OVERSAMPLE - 1));
        bit_val = rx_in;
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            xor_q   <= 1'b0;
            ppend_q <= 1'b0;
            fin_q   <= 1'b0;
            stop_q  <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            xor_q   <= xor_d;
            ppend_q <= ppend_d;
            fin_q   <= fin_d;
            stop_q  <= stop_d;
            we_q    <= we_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    // Next state: the FSM moves on baud ticks. Frame results commit one clock later.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        xor_d   = xor_q;
        ppend_d = ppend_q;
        fin_d   = 1'b0;
        stop_d  = stop_q;
        if (baud_tick) begin
            tick_d = (tick_q == TW'(OVERSAMPLE - 1)) ? '0 : tick_q + 1'b1;
            case (state_q)
                IDLE: if (!rx_in) begin
                    state_d = START;
                    tick_d  = '0;
                end
                START: if (samp) begin
                    if (bit_val) state_d = IDLE;
                    else begin
                        state_d = DATA;
                        tick_d  = TRELOAD;
                        bit_d   = '0;
                        xor_d   = 1'b0;
                        ppend_d = 1'b0;
                    end
                end
                DATA: if (samp) begin
                    shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                    xor_d   = xor_q ^ bit_val;
                    if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY_ON != 0) ? PARITY : STOP;
                    else bit_d = bit_q + 1'b1;
                end
                PARITY: if (samp) begin
                    ppend_d = xor_q ^ bit_val ^ 1'(PARITY_ODD);
                    state_d = STOP;
                end
                STOP: if (samp) begin
                    fin_d   = 1'b1;
                    stop_d  = bit_val;
                    state_d = bit_val ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: if (rx_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // On the clock after the stop decision: write, or flag why the write was dropped.
        // A set wins over err_clr in the same cycle.
        we_d   = fin_q && stop_q && !ppend_q && !fifo_full;
        data_d = we_d ? shreg_q : data_q;
        perr_d = (fin_q && stop_q && ppend_q) || (perr_q && !err_clr);
        ferr_d = (fin_q && !stop_q) || (ferr_q && !err_clr);
        oerr_d = (fin_q && stop_q && !ppend_q && fifo_full) || (oerr_q && !err_clr);
    end

    // Outputs.
    always_comb begin
        busy        = (state_q != IDLE);
        fifo_we     = we_q;
        rx_data     = data_q;
        parity_err  = perr_q;
        frame_err   = ferr_q;
        overrun_err = oerr_q;
    end
endmodule
